countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  Sequences the two right-hand seven-segment digits as a countdown timer for menu operations (e.g. operand-entry timeout).
//  Counts the clk_out domain down to 1 s ticks and decrements a 2-digit BCD value.
//  Drives the display's seconds bus: bit8 = show enable, [7:4] = tens BCD, [3:0] = units BCD.
//  Reports expiry to the menu FSM.
// PARAMETERS
//  TICKS_PER_SEC    50000  clk_out cycles per one-second tick (>=2)
//  TICK_W           16     width of tick prescaler; must satisfy 2^TICK_W > TICKS_PER_SEC
//  EXPIRE_HOLD_SECS 3      seconds "00" stays displayed after expiry before the display blanks (>=1)
// PORTS
//  clk_out        in   1  block clock (divided system clock)
//  reset          in   1  asynchronous, active-high reset
//  start          in   1  1-cycle pulse: load load_bcd and begin counting
//  pause          in   1  1-cycle pulse: toggle RUN<->PAUSE
//  cancel         in   1  1-cycle pulse: abort to IDLE, blank display
//  load_bcd       in   8  start value, [7:4] tens BCD, [3:0] units BCD
//  seconds        out  9  {show, tens, units} to display
//  busy           out  1  high in RUN or PAUSE
//  paused         out  1  high in PAUSE
//  expired        out  1  1-cycle pulse when count reaches 00
//  load_err       out  1  1-cycle pulse when start rejected (digit > 9)
// BEHAVIOUR
//  Reset: state=IDLE; seconds=9'h000; busy=paused=expired=load_err=0; prescaler=0; hold counter=0.
//  All outputs are registered. seconds updates on the clock edge after the event that changes it.
//  States:
//   IDLE    show=0. start with valid BCD -> RUN. start with invalid BCD -> stay IDLE, load_err=1.
//   RUN     show=1. Prescaler counts 0..TICKS_PER_SEC-1; at the wrap the BCD value decrements.
//           Decrement: units==0 -> units=9, tens=tens-1; otherwise units=units-1.
//           When the value becomes 00 -> EXPIRED, expired=1 for one cycle.
//   PAUSE   show=1. Value and prescaler are frozen.
//   EXPIRED show=1, value 00. Stays EXPIRE_HOLD_SECS ticks, then -> IDLE, seconds=9'h000.
//  Transitions:
//   - RUN--pause->PAUSE; PAUSE--pause->RUN. pause is ignored in IDLE and EXPIRED.
//  Loading (start in any state):
//   - start with load_bcd=00 -> EXPIRED directly; expired pulses on the next cycle.
//   - Valid start clears the prescaler, so the first decrement occurs exactly TICKS_PER_SEC cycles after the loading edge.
//   - Valid start in RUN, PAUSE or EXPIRED restarts from load_bcd (leaves PAUSE).
//   - Invalid start in RUN or PAUSE: load_err pulses; state, value and prescaler are unchanged.
//  Priority when pulses coincide in one cycle: cancel > start > pause.
//   - cancel wins in any state -> IDLE, seconds=0, no expired pulse.
//   - start+pause: start is applied and pause is dropped.
//  Boundaries:
//   - Max load 99; tens never underflows, because expiry at 00 stops decrementing.
//   - A tick coinciding with start is discarded.
//   - Reset mid-count returns everything to reset values asynchronously.
// STRUCTURE
//  Shared package/header (timer_pkg.vh): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_EXPIRED=2'd3;
//   BCD_MAX_DIGIT=4'd9; macro for the {show,tens,units} bus layout.
//  One sub-module: tick_prescaler (counter with clear and enable, emits a 1-cycle tick at TICKS_PER_SEC-1).
//  Top: FSM, BCD down-counter, hold counter, output registers.
// TESTING (TICKS_PER_SEC=4, EXPIRE_HOLD_SECS=2 for speed)
//  1. start, load_bcd=8'h12 -> seconds=9'h112 next cycle; 9'h111 after 4 cycles; 9'h109 after 12 cycles total.
//     Continue to 9'h100: expired pulses once; blank 9'h000 after 2 more ticks; busy=0.
//  2. load 8'h05, pause after 6 cycles -> value 9'h104 frozen for 20 cycles, paused=1.
//     pause again -> 9'h103 exactly 2 cycles later (prescaler resumed at 2).
//  3. start with load_bcd=8'h1A in IDLE -> load_err=1 one cycle, seconds stays 9'h000.
//     Same during RUN at 9'h107 -> count continues unaffected.
//  4. start+cancel same cycle while RUN -> IDLE, seconds=9'h000, expired never pulses.
//     start+pause same cycle -> RUN with new value, paused=0.
//  5. start load_bcd=8'h00 -> seconds=9'h100, expired pulse next cycle, blank after 2 ticks.
//     Restart with 8'h99 during EXPIRED -> 9'h199, busy=1.
//  6. Assert reset asynchronously mid-RUN (no clk edge) -> seconds=9'h000, busy=0 immediately.
//     Release reset -> remains IDLE.

Source files
------------

// File: rtl/countdown_timer_ctrl_pkg.sv
// rtl/countdown_timer_ctrl_pkg.sv - shared state encodings and BCD helpers for the countdown timer
package countdown_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, BCD_MAX_DIGIT};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Display bus layout: {show, tens, units}.
  function automatic logic [8:0] seconds_bus(input logic show, input logic [7:0] value);
    return {show, value};
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// rtl/countdown_timer_ctrl_tick_prescaler.sv - one-second tick prescaler with clear and enable
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50000,
  parameter int unsigned TICK_W        = 16
) (
  input  logic clk_out,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] cnt_q;

  // A clear in the same cycle swallows the tick.
  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset)     cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - two-digit BCD countdown timer driving the seconds display bus
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC    = 50000,
  parameter int unsigned TICK_W           = 16,
  parameter int unsigned EXPIRE_HOLD_SECS = 3
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic [7:0] load_bcd,
  output logic [8:0] seconds,
  output logic       busy,
  output logic       paused,
  output logic       expired,
  output logic       load_err
);

  localparam int unsigned HOLD_W = (EXPIRE_HOLD_SECS > 1) ? $clog2(EXPIRE_HOLD_SECS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EXPIRE_HOLD_SECS - 1);

  state_e            state_q;
  logic [7:0]        value_q;
  logic [HOLD_W-1:0] hold_q;
  logic              show_q, busy_q, paused_q, expired_q, load_err_q;

  logic       start_ok, presc_clr, presc_en, tick;
  logic [7:0] value_dec;

  assign start_ok  = start && bcd_valid(load_bcd);
  assign presc_clr = cancel || start_ok || (state_q == ST_IDLE);
  assign presc_en  = (state_q == ST_RUN) || (state_q == ST_EXPIRED);
  assign value_dec = bcd_dec(value_q);

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .TICK_W        (TICK_W)
  ) u_prescaler (
    .clk_out (clk_out),
    .reset   (reset),
    .clr     (presc_clr),
    .en      (presc_en),
    .tick    (tick)
  );

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      value_q    <= 8'h00;
      hold_q     <= '0;
      show_q     <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (cancel) begin
        state_q  <= ST_IDLE;
        value_q  <= 8'h00;
        hold_q   <= '0;
        show_q   <= 1'b0;
        busy_q   <= 1'b0;
        paused_q <= 1'b0;
      end else if (start_ok) begin
        value_q  <= load_bcd;
        hold_q   <= '0;
        show_q   <= 1'b1;
        paused_q <= 1'b0;
        if (load_bcd == 8'h00) begin
          state_q   <= ST_EXPIRED;
          busy_q    <= 1'b0;
          expired_q <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        // A rejected start still outranks pause but leaves the count running.
        if (start) load_err_q <= 1'b1;
        case (state_q)
          ST_RUN: begin
            if (tick) value_q <= value_dec;
            if (tick && value_dec == 8'h00) begin
              state_q   <= ST_EXPIRED;
              busy_q    <= 1'b0;
              expired_q <= 1'b1;
              hold_q    <= '0;
            end else if (pause && !start) begin
              state_q  <= ST_PAUSE;
              paused_q <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (pause && !start) begin
              state_q  <= ST_RUN;
              paused_q <= 1'b0;
            end
          end
          ST_EXPIRED: begin
            if (tick) begin
              if (hold_q == HOLD_LAST) begin
                state_q <= ST_IDLE;
                value_q <= 8'h00;
                show_q  <= 1'b0;
                hold_q  <= '0;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign seconds  = seconds_bus(show_q, value_q);
  assign busy     = busy_q;
  assign paused   = paused_q;
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - directed self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

  logic       clk_out = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic       pause   = 1'b0;
  logic       cancel  = 1'b0;
  logic [7:0] load_bcd = 8'h00;
  logic [8:0] seconds;
  logic       busy, paused, expired, load_err;

  int n_checks = 0;
  int n_pass   = 0;

  countdown_timer_ctrl #(
    .TICKS_PER_SEC    (4),
    .TICK_W           (3),
    .EXPIRE_HOLD_SECS (2)
  ) dut (
    .clk_out  (clk_out),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .cancel   (cancel),
    .load_bcd (load_bcd),
    .seconds  (seconds),
    .busy     (busy),
    .paused   (paused),
    .expired  (expired),
    .load_err (load_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_out);
      #1;
      start  = 1'b0;
      pause  = 1'b0;
      cancel = 1'b0;
    end
  endtask

  task automatic chk_sec(input string tag, input logic [8:0] exp);
    check_eq(tag, 16'(seconds), 16'(exp));
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step(1);
    chk_sec("reset_seconds", 9'h000);
    check_eq("reset_busy", 16'(busy), 16'd0);
    check_eq("reset_paused", 16'(paused), 16'd0);
    check_eq("reset_expired", 16'(expired), 16'd0);
    check_eq("reset_load_err", 16'(load_err), 16'd0);

    // 1: full countdown from 12
    start = 1'b1; load_bcd = 8'h12; step(1);
    chk_sec("t1_load", 9'h112);
    check_eq("t1_busy", 16'(busy), 16'd1);
    step(3);  chk_sec("t1_before_tick", 9'h112);
    step(1);  chk_sec("t1_first_dec", 9'h111);
    step(8);  chk_sec("t1_borrow", 9'h109);
    step(35); chk_sec("t1_at_01", 9'h101);
    check_eq("t1_no_early_exp", 16'(expired), 16'd0);
    step(1);  chk_sec("t1_at_00", 9'h100);
    check_eq("t1_expired", 16'(expired), 16'd1);
    check_eq("t1_busy_exp", 16'(busy), 16'd0);
    step(1);  check_eq("t1_expired_once", 16'(expired), 16'd0);
    step(6);  chk_sec("t1_hold", 9'h100);
    step(1);  chk_sec("t1_blank", 9'h000);
    check_eq("t1_idle_busy", 16'(busy), 16'd0);

    // 2: pause freezes value and prescaler
    start = 1'b1; load_bcd = 8'h05; step(1);
    step(4);  chk_sec("t2_first_dec", 9'h104);
    step(1);
    pause = 1'b1; step(1);
    check_eq("t2_paused", 16'(paused), 16'd1);
    step(20); chk_sec("t2_frozen", 9'h104);
    check_eq("t2_busy_paused", 16'(busy), 16'd1);
    pause = 1'b1; step(1);
    check_eq("t2_resumed", 16'(paused), 16'd0);
    step(1);  chk_sec("t2_resume_1", 9'h104);
    step(1);  chk_sec("t2_resume_2", 9'h103);
    cancel = 1'b1; step(1);
    chk_sec("t2_cancel", 9'h000);

    // 3: rejected loads
    start = 1'b1; load_bcd = 8'h1A; step(1);
    check_eq("t3_err_idle", 16'(load_err), 16'd1);
    chk_sec("t3_idle_seconds", 9'h000);
    step(1);  check_eq("t3_err_pulse", 16'(load_err), 16'd0);
    start = 1'b1; load_bcd = 8'h08; step(1);
    step(4);  chk_sec("t3_at_07", 9'h107);
    start = 1'b1; load_bcd = 8'h1A; step(1);
    check_eq("t3_err_run", 16'(load_err), 16'd1);
    chk_sec("t3_run_kept", 9'h107);
    step(2);  chk_sec("t3_still_07", 9'h107);
    step(1);  chk_sec("t3_unaffected", 9'h106);

    // 4: coincident pulses
    start = 1'b1; cancel = 1'b1; load_bcd = 8'h50; step(1);
    chk_sec("t4_cancel_wins", 9'h000);
    check_eq("t4_cancel_busy", 16'(busy), 16'd0);
    step(8);  check_eq("t4_no_expire", 16'(expired), 16'd0);
    chk_sec("t4_stays_idle", 9'h000);
    start = 1'b1; load_bcd = 8'h30; step(1);
    pause = 1'b1; step(1);
    check_eq("t4_in_pause", 16'(paused), 16'd1);
    start = 1'b1; pause = 1'b1; load_bcd = 8'h23; step(1);
    chk_sec("t4_start_pause", 9'h123);
    check_eq("t4_pause_dropped", 16'(paused), 16'd0);
    step(4);  chk_sec("t4_running", 9'h122);
    cancel = 1'b1; step(1);

    // 5: zero load and restart during hold
    start = 1'b1; load_bcd = 8'h00; step(1);
    chk_sec("t5_zero", 9'h100);
    check_eq("t5_expired", 16'(expired), 16'd1);
    step(1);  check_eq("t5_expired_once", 16'(expired), 16'd0);
    step(6);  chk_sec("t5_hold", 9'h100);
    step(1);  chk_sec("t5_blank", 9'h000);
    start = 1'b1; load_bcd = 8'h00; step(1);
    step(2);
    start = 1'b1; load_bcd = 8'h99; step(1);
    chk_sec("t5_restart", 9'h199);
    check_eq("t5_restart_busy", 16'(busy), 16'd1);

    // 6: asynchronous reset mid-run
    step(2);
    #2 reset = 1'b1;
    #1;
    chk_sec("t6_async_seconds", 9'h000);
    check_eq("t6_async_busy", 16'(busy), 16'd0);
    #1 reset = 1'b0;
    step(6);
    chk_sec("t6_idle_after", 9'h000);
    check_eq("t6_idle_busy", 16'(busy), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
